// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// State encodings and default memory widths.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_st_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way requester pick for the dmem arbiter.
// Round-robin against the last grant, or fixed port-0 priority.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // pick the winner among the current requests
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    unique case (req)
      2'b11:   gnt_id = rr_en ? ~last : 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the line-wide data memory port between dcache and icache.
// One grant per transaction, ack routed only to the granted port.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int LINE_W      = DMEM_LINE_W,
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] m_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  localparam bit         TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  arb_st_e    state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic       gnt_valid, gnt_id;
  logic       sel1, expired;

  rr_pick2 u_pick (
    .req       ({m1_enable_i, m0_enable_i}),
    .last      (last_q),
    .rr_en     (RR_EN != 0),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign m_data_o  = mem_data_i;
  assign timeout_o = to_q;

  // state, last-grant, watchdog and sticky timeout registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // next state and memory-side mux of the granted port
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    sel1         = (state_q == ST_GNT1);
    expired      = TO_EN && (cnt_q == TO_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = gnt_id ? ST_GNT1 : ST_GNT0;
          last_d  = gnt_id;
          cnt_d   = '0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        mem_enable_o = 1'b1;
        mem_write_o  = sel1 ? m1_write_i : m0_write_i;
        mem_addr_o   = sel1 ? m1_addr_i : m0_addr_i;
        mem_data_o   = sel1 ? m1_data_i : m0_data_i;
        m0_ack_o     = mem_ack_i & ~sel1;
        m1_ack_o     = mem_ack_i & sel1;
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter.
// Requesters queue expectations, a monitor checks acks and grants.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          m0_en = 0, m0_we = 0, m0_ack;
  logic [AW-1:0] m0_ad = '0;
  logic [LW-1:0] m0_wd = '0;
  logic          m1_en = 0, m1_we = 0, m1_ack;
  logic [AW-1:0] m1_ad = '0;
  logic [LW-1:0] m1_wd = '0;
  logic [LW-1:0] m_data, mem_wd;
  logic [LW-1:0] mem_rd = '0;
  logic          mem_en, mem_we, to;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_ad;

  logic          f0_en = 0, f1_en = 0;
  logic          f_ack0, f_ack1, f_men, f_mwe, f_to;
  logic          f_mack = 1'b0;
  logic [AW-1:0] f_mad;
  logic [LW-1:0] f_mdata, f_mwd;

  dmem_port_arbiter #(.RR_EN(1), .TIMEOUT_CYC(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_en), .m0_write_i(m0_we),
    .m0_addr_i(m0_ad), .m0_data_i(m0_wd), .m0_ack_o(m0_ack),
    .m1_enable_i(m1_en), .m1_write_i(m1_we),
    .m1_addr_i(m1_ad), .m1_data_i(m1_wd), .m1_ack_o(m1_ack),
    .m_data_o(m_data), .mem_enable_o(mem_en),
    .mem_write_o(mem_we), .mem_addr_o(mem_ad),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd),
    .mem_ack_i(mem_ack), .timeout_o(to)
  );

  dmem_port_arbiter #(.RR_EN(0), .TIMEOUT_CYC(0)) u_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(f0_en), .m0_write_i(1'b0),
    .m0_addr_i(32'h100), .m0_data_i('0), .m0_ack_o(f_ack0),
    .m1_enable_i(f1_en), .m1_write_i(1'b0),
    .m1_addr_i(32'h8100), .m1_data_i('0), .m1_ack_o(f_ack1),
    .m_data_o(f_mdata), .mem_enable_o(f_men),
    .mem_write_o(f_mwe), .mem_addr_o(f_mad),
    .mem_data_o(f_mwd), .mem_data_i('0),
    .mem_ack_i(f_mack), .timeout_o(f_to)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [LW-1:0] wd;
    logic [LW-1:0] rd;
  } txn_t;

  txn_t          q0[$];
  txn_t          q1[$];
  logic [LW-1:0] shadow[int unsigned];
  logic [LW-1:0] mem[int unsigned];
  int            glog[$];
  int            checks = 0;
  int            errors = 0;
  int            mdl_last = 1;
  int            lat_fix = -1;
  bit            mute = 0;
  bit            chk_en = 0;
  bit            prev_en, prev_r0, prev_r1, prev_ack;
  int            exp_w, act_w;

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input int p, input logic we,
                        input logic [AW-1:0] ad,
                        input logic [LW-1:0] wd);
    txn_t t;
    int   n;
    logic a;
    t.we = we;
    t.ad = ad;
    t.wd = wd;
    t.rd = shadow.exists(ad) ? shadow[ad] : pat(ad);
    if (we) shadow[ad] = wd;
    if (p == 0) begin
      q0.push_back(t);
      m0_en = 1; m0_we = we; m0_ad = ad; m0_wd = wd;
    end else begin
      q1.push_back(t);
      m1_en = 1; m1_we = we; m1_ad = ad; m1_wd = wd;
    end
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      a = (p == 0) ? m0_ack : m1_ack;
    end while (!a && n < 300);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL ack_wait port=%0d act=none exp=ack", p);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic release_port(input int p);
    if (p == 0) m0_en = 0;
    else m1_en = 0;
  endtask

  task automatic sb_pop(input int p);
    txn_t t;
    int   sz;
    sz = (p == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack port=%0d act=ack exp=none", p);
      return;
    end
    if (p == 0) t = q0.pop_front();
    else t = q1.pop_front();
    chk("ack_addr", mem_ad, t.ad);
    chk("ack_write", mem_we, t.we);
    if (t.we) chk("ack_wdata", mem_wd, t.wd);
    else chk("ack_rdata", m_data, t.rd);
  endtask

  // monitor: ack scoreboard, grant choice, latency and idle gap
  always @(negedge clk_i) begin
    if (chk_en) begin
      if (m0_ack) sb_pop(0);
      if (m1_ack) sb_pop(1);
      if (!prev_en && mem_en) begin
        chk("grant_has_req", prev_r0 | prev_r1, 1);
        if (prev_r0 && prev_r1) exp_w = 1 - mdl_last;
        else exp_w = prev_r1 ? 1 : 0;
        act_w = mem_ad[15] ? 1 : 0;
        chk("grant_winner", act_w, exp_w);
        mdl_last = exp_w;
        glog.push_back(act_w);
      end else if (!prev_en && (prev_r0 || prev_r1)) begin
        chk("grant_latency", mem_en, 1);
      end
      if (prev_ack) chk("idle_gap", mem_en, 0);
    end
    prev_en  = mem_en;
    prev_r0  = m0_en;
    prev_r1  = m1_en;
    prev_ack = mem_ack & mem_en;
  end

  // memory model for the round-robin instance
  initial begin
    forever begin : resp
      int lat;
      @(posedge clk_i);
      #1;
      if (mem_en && rst_i && !mute) begin
        lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 6);
        repeat (lat) begin
          @(posedge clk_i);
          #1;
        end
        if (rst_i && !mute) begin
          mem_rd = mem.exists(mem_ad) ? mem[mem_ad] : pat(mem_ad);
          if (mem_we) mem[mem_ad] = mem_wd;
          mem_ack = 1;
          @(posedge clk_i);
          #1;
          mem_ack = 0;
        end
      end
    end
  end

  // memory model for the fixed-priority instance
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (f_men) begin
        repeat (2) begin
          @(posedge clk_i);
          #1;
        end
        f_mack = 1;
        @(posedge clk_i);
        #1;
        f_mack = 0;
      end
    end
  end

  initial begin
    int n, k, a0, a1;
    bit got;
    repeat (3) @(negedge clk_i);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_ad", mem_ad, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_timeout", to, 0);
    @(posedge clk_i);
    #1;
    rst_i  = 1;
    chk_en = 1;

    glog.delete();
    fork
      begin
        do_txn(0, 0, 32'h440, '0);
        do_txn(0, 0, 32'h480, '0);
        release_port(0);
      end
      begin
        do_txn(1, 0, 32'h8040, '0);
        do_txn(1, 0, 32'h8080, '0);
        release_port(1);
      end
    join
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("rr_order", glog[i], i % 2);
    repeat (2) @(posedge clk_i);
    #1;

    lat_fix = 10;
    do_txn(0, 0, 32'h400, '0);
    release_port(0);
    lat_fix = -1;
    repeat (2) @(posedge clk_i);
    #1;

    do_txn(0, 1, 32'h7E0, {32{8'hA5}});
    do_txn(0, 0, 32'h1000, '0);
    do_txn(0, 0, 32'h7E0, '0);
    release_port(0);
    repeat (2) @(posedge clk_i);
    #1;

    mem_ack = 1;
    @(negedge clk_i);
    chk("idle_ack_ignored", {m0_ack, m1_ack}, 0);
    @(posedge clk_i);
    #1;
    mem_ack = 0;

    fork
      begin
        for (int i = 0; i < 25; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            release_port(0);
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
          end
          do_txn(0, 1'($urandom_range(0, 1)),
                 32'h20 * $urandom_range(0, 7),
                 {8{$urandom()}});
        end
        release_port(0);
      end
      begin
        for (int i = 0; i < 25; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            release_port(1);
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
          end
          do_txn(1, 1'($urandom_range(0, 1)),
                 32'h8000 + 32'h20 * $urandom_range(0, 7),
                 {8{$urandom()}});
        end
        release_port(1);
      end
    join
    repeat (3) @(posedge clk_i);
    #1;
    chk("queues_drained", q0.size() + q1.size(), 0);

    mute  = 1;
    m0_en = 1; m0_we = 0; m0_ad = 32'h600;
    @(posedge clk_i);
    #1;
    m0_en = 0;
    n = 0;
    k = 0;
    do begin
      @(negedge clk_i);
      if (mem_en) n++;
      k++;
    end while (mem_en && k < 40);
    chk("timeout_len", n, 16);
    chk("timeout_flag", to, 1);
    repeat (5) @(negedge clk_i);
    chk("timeout_sticky", to, 1);

    @(posedge clk_i);
    #1;
    m1_en = 1; m1_we = 0; m1_ad = 32'h8200;
    @(posedge clk_i);
    #1;
    chk("gnt1_before_rst", {mem_en, mem_ad[15]}, 2'b11);
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 0;
    rst_i  = 0;
    #1;
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_ad", mem_ad, 0);
    chk("arst_acks", {m0_ack, m1_ack}, 0);
    chk("arst_timeout", to, 0);
    @(posedge clk_i);
    #1;
    mdl_last = 1;
    mute     = 0;
    glog.delete();
    fork
      begin
        do_txn(0, 0, 32'h840, '0);
        release_port(0);
      end
      begin
        do_txn(1, 0, 32'h8240, '0);
        release_port(1);
      end
      begin
        @(posedge clk_i);
        #1;
        rst_i = 1;
        @(negedge clk_i);
        #1;
        chk_en = 1;
      end
    join
    chk("post_rst_first", glog.size() > 0 ? glog[0] : 9, 0);
    repeat (2) @(posedge clk_i);
    #1;

    a0 = 0;
    a1 = 0;
    f0_en = 1;
    f1_en = 1;
    repeat (60) begin
      @(negedge clk_i);
      if (f_ack0) a0++;
      if (f_ack1) a1++;
    end
    chk("fp_p1_starved", a1, 0);
    chk("fp_p0_regranted", a0 >= 10, 1);
    @(posedge clk_i);
    #1;
    f0_en = 0;
    got = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (f_ack1) got = 1;
    end
    chk("fp_p1_after_drop", got, 1);
    f1_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
